// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_ctrl
// Description : Sequencer between the UART receiver, a combinational ALU and
//               the UART transmitter. It collects operand A, operand B and an
//               opcode, registers the ALU result and launches one transmit of
//               it. A partial frame is aborted after an inter-byte timeout
//               counted in baud ticks. Bytes that arrive while a result is
//               pending are dropped and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl #(
    parameter int DBIT     = 8,
    parameter int OP_W     = 6,
    parameter int TO_TICKS = 640,
    parameter int TO_W     = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx_done_tick,
    input  logic [DBIT-1:0] rx_data,
    input  logic [DBIT-1:0] alu_result,
    input  logic            tx_done_tick,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [OP_W-1:0] alu_op,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_data,
    output logic            busy,
    output logic            overrun_tick,
    output logic            timeout_tick
);

    localparam logic [2:0] c_GET_A   = 3'd0;
    localparam logic [2:0] c_GET_B   = 3'd1;
    localparam logic [2:0] c_GET_OP  = 3'd2;
    localparam logic [2:0] c_LATCH   = 3'd3;
    localparam logic [2:0] c_SEND    = 3'd4;
    localparam logic [2:0] c_WAIT_TX = 3'd5;

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TO_TICKS - 1);
    localparam logic [TO_W-1:0] c_TO_ONE  = TO_W'(1);

    logic [2:0]      r_state;
    logic [TO_W-1:0] r_to_cnt;
    logic [DBIT-1:0] r_alu_a;
    logic [DBIT-1:0] r_alu_b;
    logic [OP_W-1:0] r_alu_op;
    logic [DBIT-1:0] r_tx_data;

    logic w_mid_frame;
    logic w_busy;
    logic w_to_hit;

    // The timeout only runs once at least one byte of a frame has arrived.
    assign w_mid_frame = (r_state == c_GET_B) || (r_state == c_GET_OP);
    assign w_busy      = (r_state == c_LATCH) || (r_state == c_SEND) ||
                         (r_state == c_WAIT_TX);
    // Limit reached on this tick; a byte in the same cycle still wins.
    assign w_to_hit    = w_mid_frame && s_tick && (r_to_cnt == c_TO_LAST);

    // Frame sequencer, timeout counter and the registered datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_GET_A;
            r_to_cnt  <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_tx_data <= '0;
        end else begin
            // Counter sits at zero unless a mid-frame state says otherwise.
            r_to_cnt <= '0;
            case (r_state)
                c_GET_A: begin
                    if (rx_done_tick) begin
                        r_alu_a <= rx_data;
                        r_state <= c_GET_B;
                    end
                end
                c_GET_B: begin
                    if (rx_done_tick) begin
                        r_alu_b <= rx_data;
                        r_state <= c_GET_OP;
                    end else if (w_to_hit) begin
                        r_state <= c_GET_A;
                    end else if (s_tick) begin
                        r_to_cnt <= r_to_cnt + c_TO_ONE;
                    end else begin
                        r_to_cnt <= r_to_cnt;
                    end
                end
                c_GET_OP: begin
                    if (rx_done_tick) begin
                        r_alu_op <= rx_data[OP_W-1:0];
                        r_state  <= c_LATCH;
                    end else if (w_to_hit) begin
                        r_state <= c_GET_A;
                    end else if (s_tick) begin
                        r_to_cnt <= r_to_cnt + c_TO_ONE;
                    end else begin
                        r_to_cnt <= r_to_cnt;
                    end
                end
                c_LATCH: begin
                    // ALU inputs have been stable for a full cycle here.
                    r_tx_data <= alu_result;
                    r_state   <= c_SEND;
                end
                c_SEND: begin
                    r_state <= c_WAIT_TX;
                end
                c_WAIT_TX: begin
                    if (tx_done_tick) begin
                        r_state <= c_GET_A;
                    end
                end
                default: begin
                    r_state <= c_GET_A;
                end
            endcase
        end
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign tx_data      = r_tx_data;
    assign tx_start     = (r_state == c_SEND);
    assign busy         = w_busy;
    assign overrun_tick = w_busy && rx_done_tick;
    assign timeout_tick = w_to_hit && !rx_done_tick;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_alu_ctrl
// Description : Directed testbench for uart_alu_ctrl. A small ALU stand-in
//               (0x22 subtracts, every other opcode adds) feeds alu_result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_ctrl;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic [7:0] alu_result;
    logic       tx_done_tick;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       overrun_tick;
    logic       timeout_tick;

    int n_tests;
    int n_fail;

    uart_alu_ctrl #(
        .DBIT     (8),
        .OP_W     (6),
        .TO_TICKS (640),
        .TO_W     (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .alu_result   (alu_result),
        .tx_done_tick (tx_done_tick),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .busy         (busy),
        .overrun_tick (overrun_tick),
        .timeout_tick (timeout_tick)
    );

    // ALU stand-in.
    assign alu_result = (alu_op == 6'h22) ? (alu_a - alu_b) : (alu_a + alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one byte for one cycle; returns on the negedge after capture.
    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    // One s_tick pulse followed by one quiet cycle.
    task automatic pulse_tick();
        s_tick = 1'b1;
        @(negedge clk);
        s_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic finish_tx();
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (alu_a !== 8'h00) begin n_fail++; $display("FAIL reset_alu_a: got %02h expected 00", alu_a); end
        n_tests++; if (alu_b !== 8'h00) begin n_fail++; $display("FAIL reset_alu_b: got %02h expected 00", alu_b); end
        n_tests++; if (alu_op !== 6'h00) begin n_fail++; $display("FAIL reset_alu_op: got %02h expected 00", alu_op); end
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %02h expected 00", tx_data); end
        n_tests++; if ({tx_start, busy, overrun_tick, timeout_tick} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {tx_start, busy, overrun_tick, timeout_tick});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_no_timeout();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 700; i++) begin
            s_tick = 1'b1;
            #1 if (timeout_tick !== 1'b0) seen = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
            @(negedge clk);
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: got 1 expected 0"); end
    endtask

    task automatic test_nominal();
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        n_tests++; if (alu_a !== 8'h05) begin n_fail++; $display("FAIL nom_alu_a: got %02h expected 05", alu_a); end
        n_tests++; if (alu_b !== 8'h03) begin n_fail++; $display("FAIL nom_alu_b: got %02h expected 03", alu_b); end
        n_tests++; if (alu_op !== 6'h20) begin n_fail++; $display("FAIL nom_alu_op: got %02h expected 20", alu_op); end
        n_tests++; if ({busy, tx_start} !== 2'b10) begin n_fail++; $display("FAIL nom_latch: got busy,tx_start=%b expected 10", {busy, tx_start}); end
        @(negedge clk);
        n_tests++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL nom_tx_start: got %b expected 1", tx_start); end
        n_tests++; if (tx_data !== 8'h08) begin n_fail++; $display("FAIL nom_tx_data: got %02h expected 08", tx_data); end
        @(negedge clk);
        n_tests++; if ({busy, tx_start} !== 2'b10) begin n_fail++; $display("FAIL nom_wait: got busy,tx_start=%b expected 10", {busy, tx_start}); end
        repeat (3) @(negedge clk);
        n_tests++; if (tx_data !== 8'h08 || busy !== 1'b1) begin
            n_fail++; $display("FAIL nom_hold: got tx_data=%02h busy=%b expected 08 1", tx_data, busy);
        end
        finish_tx();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nom_done: got busy=%b expected 0", busy); end
        // tx_done outside WAIT_TX must change nothing.
        finish_tx();
        n_tests++; if ({busy, tx_start} !== 2'b00) begin n_fail++; $display("FAIL stray_tx_done: got %b expected 00", {busy, tx_start}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fr [3];
        logic ov;
        fr[0] = 8'hFF; fr[1] = 8'h01; fr[2] = 8'h22;
        // Restart a frame straight after tx_done of the previous one.
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h20);
        @(negedge clk);
        @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        ov = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_data      = fr[i];
            rx_done_tick = 1'b1;
            #1 if (overrun_tick !== 1'b0) ov = 1'b1;
            @(negedge clk);
            rx_done_tick = 1'b0;
        end
        n_tests++; if (ov !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got 1 expected 0"); end
        @(negedge clk);
        n_tests++; if (tx_start !== 1'b1 || tx_data !== 8'hFE) begin
            n_fail++; $display("FAIL b2b_tx: got tx_start=%b tx_data=%02h expected 1 FE", tx_start, tx_data);
        end
        @(negedge clk);
        finish_tx();
    endtask

    task automatic test_timeout();
        logic early;
        send_byte(8'h11);
        early = 1'b0;
        for (int i = 0; i < 639; i++) begin
            s_tick = 1'b1;
            #1 if (timeout_tick !== 1'b0) early = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
            @(negedge clk);
        end
        n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL to_early: got 1 expected 0"); end
        s_tick = 1'b1;
        #1;
        n_tests++; if (timeout_tick !== 1'b1) begin n_fail++; $display("FAIL to_tick: got %b expected 1", timeout_tick); end
        @(negedge clk);
        s_tick = 1'b0;
        #1;
        n_tests++; if (timeout_tick !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL to_after: got timeout=%b busy=%b expected 0 0", timeout_tick, busy);
        end
        send_byte(8'h02);
        n_tests++; if (alu_a !== 8'h02 || alu_b !== 8'h01) begin
            n_fail++; $display("FAIL to_fresh: got alu_a=%02h alu_b=%02h expected 02 01", alu_a, alu_b);
        end
        send_byte(8'h02);
        send_byte(8'h20);
        @(negedge clk);
        n_tests++; if (tx_start !== 1'b1 || tx_data !== 8'h04) begin
            n_fail++; $display("FAIL to_frame: got tx_start=%b tx_data=%02h expected 1 04", tx_start, tx_data);
        end
        @(negedge clk);
        finish_tx();
    endtask

    task automatic test_race();
        logic early;
        send_byte(8'h33);
        for (int i = 0; i < 639; i++) pulse_tick();
        s_tick       = 1'b1;
        rx_data      = 8'h44;
        rx_done_tick = 1'b1;
        #1;
        n_tests++; if (timeout_tick !== 1'b0) begin n_fail++; $display("FAIL race_timeout: got %b expected 0", timeout_tick); end
        @(negedge clk);
        s_tick       = 1'b0;
        rx_done_tick = 1'b0;
        n_tests++; if (alu_b !== 8'h44) begin n_fail++; $display("FAIL race_alu_b: got %02h expected 44", alu_b); end
        early = 1'b0;
        for (int i = 0; i < 639; i++) begin
            s_tick = 1'b1;
            #1 if (timeout_tick !== 1'b0) early = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
            @(negedge clk);
        end
        n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL race_op_early: got 1 expected 0"); end
        send_byte(8'h20);
        @(negedge clk);
        n_tests++; if (tx_start !== 1'b1 || tx_data !== 8'h77) begin
            n_fail++; $display("FAIL race_frame: got tx_start=%b tx_data=%02h expected 1 77", tx_start, tx_data);
        end
        @(negedge clk);
        finish_tx();
    endtask

    task automatic test_overrun();
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h20);
        @(negedge clk);
        @(negedge clk);
        rx_data      = 8'hAA;
        rx_done_tick = 1'b1;
        #1;
        n_tests++; if (overrun_tick !== 1'b1) begin n_fail++; $display("FAIL ovr_tick: got %b expected 1", overrun_tick); end
        @(negedge clk);
        rx_done_tick = 1'b0;
        #1;
        n_tests++; if (overrun_tick !== 1'b0) begin n_fail++; $display("FAIL ovr_width: got %b expected 0", overrun_tick); end
        n_tests++; if (alu_a !== 8'h10 || busy !== 1'b1 || tx_data !== 8'h30) begin
            n_fail++; $display("FAIL ovr_hold: got alu_a=%02h busy=%b tx_data=%02h expected 10 1 30", alu_a, busy, tx_data);
        end
        @(negedge clk);
        rx_data      = 8'hBB;
        rx_done_tick = 1'b1;
        tx_done_tick = 1'b1;
        #1;
        n_tests++; if (overrun_tick !== 1'b1) begin n_fail++; $display("FAIL ovr_done_tick: got %b expected 1", overrun_tick); end
        @(negedge clk);
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        n_tests++; if (busy !== 1'b0 || alu_a !== 8'h10) begin
            n_fail++; $display("FAIL ovr_done_state: got busy=%b alu_a=%02h expected 0 10", busy, alu_a);
        end
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h20);
        @(negedge clk);
        n_tests++; if (tx_start !== 1'b1 || tx_data !== 8'h03 || alu_a !== 8'h01) begin
            n_fail++; $display("FAIL ovr_next: got tx_start=%b tx_data=%02h alu_a=%02h expected 1 03 01", tx_start, tx_data, alu_a);
        end
        @(negedge clk);
        finish_tx();
    endtask

    task automatic test_async_reset();
        logic spur;
        send_byte(8'h07);
        send_byte(8'h01);
        send_byte(8'h20);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_tests++; if ({alu_a, alu_op, tx_data} !== 22'd0 || {busy, tx_start} !== 2'b00) begin
            n_fail++; $display("FAIL arst_tx: got a=%02h op=%02h tx=%02h busy=%b start=%b expected all 0", alu_a, alu_op, tx_data, busy, tx_start);
        end
        @(negedge clk);
        reset = 1'b1;
        spur = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 if (tx_start !== 1'b0 || busy !== 1'b0) spur = 1'b1;
            @(negedge clk);
        end
        n_tests++; if (spur !== 1'b0) begin n_fail++; $display("FAIL arst_tx_spurious: got 1 expected 0"); end
        send_byte(8'h09);
        send_byte(8'h0A);
        #2 reset = 1'b0;
        #1;
        n_tests++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin
            n_fail++; $display("FAIL arst_op: got alu_a=%02h alu_b=%02h expected 00 00", alu_a, alu_b);
        end
        @(negedge clk);
        reset = 1'b1;
        spur = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 if (tx_start !== 1'b0 || busy !== 1'b0) spur = 1'b1;
            @(negedge clk);
        end
        n_tests++; if (spur !== 1'b0) begin n_fail++; $display("FAIL arst_op_spurious: got 1 expected 0"); end
        send_byte(8'h05);
        n_tests++; if (alu_a !== 8'h05 || alu_b !== 8'h00) begin
            n_fail++; $display("FAIL arst_restart: got alu_a=%02h alu_b=%02h expected 05 00", alu_a, alu_b);
        end
        send_byte(8'h06);
        send_byte(8'h20);
        @(negedge clk);
        n_tests++; if (tx_start !== 1'b1 || tx_data !== 8'h0B) begin
            n_fail++; $display("FAIL arst_frame: got tx_start=%b tx_data=%02h expected 1 0B", tx_start, tx_data);
        end
        @(negedge clk);
        finish_tx();
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b0;
        s_tick       = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        tx_done_tick = 1'b0;
        test_reset();
        test_idle_no_timeout();
        test_nominal();
        test_back_to_back();
        test_timeout();
        test_race();
        test_overrun();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Sequencer between the UART receiver, the combinational ALU and the UART transmitter.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents the bytes to the ALU, registers the result and launches one transmit of it.
- Aborts a partial frame after an inter-byte timeout measured in baud ticks.
- Drops and flags bytes that arrive while a result is pending.

Parameters:
DBIT, 8, data width of received bytes, operands and result.
OP_W, 6, opcode width; taken from rx_data[OP_W-1:0].
TO_TICKS, 640, s_tick count with no byte that aborts a partial frame (4 byte times at 16x oversampling).
TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TO_TICKS.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
s_tick  in  1  baud oversampling tick, 1-cycle pulse
rx_done_tick  in  1  byte-received pulse from the UART receiver
rx_data  in  DBIT  received byte, valid while rx_done_tick=1
alu_result  in  DBIT  combinational ALU output
tx_done_tick  in  1  transmit-complete pulse from the UART transmitter
alu_a  out  DBIT  registered operand A
alu_b  out  DBIT  registered operand B
alu_op  out  OP_W  registered opcode
tx_start  out  1  1-cycle transmit request
tx_data  out  DBIT  registered result, stable from tx_start until tx_done_tick
busy  out  1  high in states LATCH, SEND, WAIT_TX
overrun_tick  out  1  1-cycle pulse when a received byte is dropped
timeout_tick  out  1  1-cycle pulse when a partial frame is aborted

Behaviour:
- Reset (reset=0, asynchronous): state=GET_A; alu_a, alu_b, alu_op, tx_data=0; timeout counter=0.
- Reset values of pulse outputs: tx_start, overrun_tick, timeout_tick=0; busy=0.
- Reset mid-frame or mid-transmit discards all state immediately; no tx_start follows the reset release.
- States: GET_A, GET_B, GET_OP, LATCH, SEND, WAIT_TX.
- GET_A: on rx_done_tick, alu_a<=rx_data, go to GET_B. No timeout applies in this state.
- GET_B: on rx_done_tick, alu_b<=rx_data, go to GET_OP.
- GET_OP: on rx_done_tick, alu_op<=rx_data[OP_W-1:0], go to LATCH.
- LATCH: one cycle for the ALU to settle. tx_data<=alu_result, go to SEND.
- SEND: tx_start=1 for exactly this cycle, go to WAIT_TX.
- WAIT_TX: on tx_done_tick, go to GET_A. Operand and opcode registers hold their values; they are overwritten only by the next frame.
- Latency: tx_start is asserted 2 clk cycles after the rx_done_tick that carries the opcode.
- Timeout counter:
  - Cleared on entry to GET_B or GET_OP and on every rx_done_tick.
  - Increments on s_tick while in GET_B or GET_OP.
  - When it reaches TO_TICKS-1 and s_tick is high: timeout_tick=1, go to GET_A, clear the counter.
  - Bytes already captured stay in their registers.
  - Counter is held at 0 in all other states.
- Simultaneous rx_done_tick and timeout in the same cycle: the byte wins. It is captured and the state advances; no timeout_tick.
- rx_done_tick in LATCH, SEND or WAIT_TX: byte dropped, overrun_tick=1 that cycle, state unaffected.
- tx_done_tick outside WAIT_TX: ignored.
- rx_done_tick and tx_done_tick in the same WAIT_TX cycle: return to GET_A, byte dropped, overrun_tick=1.
- Output timing: all outputs are registered except tx_start, busy, overrun_tick and timeout_tick, which are decoded from state and inputs (Moore/Mealy mix as stated above).

Test Plan:
- Nominal frame: bytes 0x05, 0x03, 0x20 (ADD), ALU returns 0x08 -> alu_a=0x05, alu_b=0x03, alu_op=0x20; tx_start pulse 2 cycles after the third rx_done_tick; tx_data=0x08 held; busy high until tx_done_tick, then state GET_A.
- Back-to-back frames: second frame 0xFF, 0x01, 0x22 sent right after tx_done_tick -> second tx_start with tx_data = new alu_result; no overrun_tick.
- Timeout: send 0x11 only, then 640 s_ticks with no byte -> timeout_tick on the 640th tick, state GET_A. Next bytes 0x02, 0x02, 0x20 form a fresh frame with alu_a=0x02.
- Race at the limit: rx_done_tick coincident with the 640th s_tick in GET_B -> byte captured into alu_b, state GET_OP, no timeout_tick.
- Overrun: rx_done_tick with 0xAA during WAIT_TX -> overrun_tick=1 for one cycle; alu_a unchanged; the frame after tx_done_tick completes normally.
- Async reset: pull reset low while in WAIT_TX and again mid-GET_OP -> all outputs 0 immediately, state GET_A, no spurious tx_start after release.
